snapreg_seq: RTL and testbench



---
 rtl/snapreg_seq.sv | 154 +++++++++++++++
 tb/tb_snapreg_seq.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snapreg_seq.sv
// Snapshot-regfile initiator: walks a contiguous GPR range in interface-sized batches,
// sending GPR values on save and writing returned values back to the GPR file on restore.
module snapreg_seq #(
    parameter int unsigned RS_MAX = 4,
    parameter int unsigned RD_MAX = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,

    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_restore,
    input  logic [4:0]               cmd_start,
    input  logic [5:0]               cmd_len,
    output logic                     done_o,
    output logic                     err_o,

    output logic                     sreg_req,
    output logic [6:0]               sreg_funct7,
    output logic [4:0]               sreg_batch_start,
    output logic [4:0]               sreg_batch_len,
    output logic [RS_MAX-1:0][31:0]  sreg_rs_val,
    input  logic                     sreg_ack,
    input  logic                     sreg_error,
    input  logic [RD_MAX-1:0][31:0]  sreg_rd_val,

    output logic [RS_MAX-1:0][4:0]   rf_raddr,
    input  logic [RS_MAX-1:0][31:0]  rf_rdata,
    output logic [RD_MAX-1:0]        rf_we,
    output logic [RD_MAX-1:0][4:0]   rf_waddr,
    output logic [RD_MAX-1:0][31:0]  rf_wdata
);

    localparam logic [6:0] Funct7Save    = 7'b0000000;
    localparam logic [6:0] Funct7Restore = 7'b1000000;

    typedef enum logic [1:0] {StIdle, StReq, StFin} state_e;

    state_e     state_q, state_d;
    logic       restore_q, restore_d;
    logic [4:0] cur_q, cur_d;
    logic [5:0] rem_q, rem_d;
    logic       err_q, err_d;

    logic [6:0] cmd_end;
    logic       cmd_legal;
    logic [5:0] max_w;
    logic [5:0] blen;
    logic [5:0] rem_next;
    logic       batch_ok;

    // Range check in 7 bits so start+len cannot wrap past 32.
    assign cmd_end   = {2'b00, cmd_start} + {1'b0, cmd_len};
    assign cmd_legal = (cmd_len != 6'd0) && (cmd_len <= 6'd32) && (cmd_end <= 7'd32);

    assign max_w    = restore_q ? 6'(RD_MAX) : 6'(RS_MAX);
    assign blen     = (rem_q < max_w) ? rem_q : max_w;
    assign rem_next = rem_q - blen;
    assign batch_ok = (state_q == StReq) && sreg_ack && !sreg_error;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            restore_q <= 1'b0;
            cur_q     <= 5'd0;
            rem_q     <= 6'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            restore_q <= restore_d;
            cur_q     <= cur_d;
            rem_q     <= rem_d;
            err_q     <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        restore_d = restore_q;
        cur_d     = cur_q;
        rem_d     = rem_q;
        err_d     = err_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    restore_d = cmd_restore;
                    cur_d     = cmd_start;
                    rem_d     = cmd_len;
                    err_d     = !cmd_legal;
                    state_d   = cmd_legal ? StReq : StFin;
                end
            end
            StReq: begin
                if (sreg_ack) begin
                    if (sreg_error) begin
                        err_d   = 1'b1;
                        state_d = StFin;
                    end else begin
                        cur_d = cur_q + blen[4:0];
                        rem_d = rem_next;
                        if (rem_next == 6'd0) begin
                            state_d = StFin;
                        end
                    end
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Control outputs
    always_comb begin
        cmd_ready        = (state_q == StIdle);
        sreg_req         = (state_q == StReq);
        done_o           = (state_q == StFin);
        err_o            = (state_q == StFin) && err_q;
        sreg_funct7      = 7'd0;
        sreg_batch_start = 5'd0;
        sreg_batch_len   = 5'd0;
        if (state_q == StReq) begin
            sreg_funct7      = restore_q ? Funct7Restore : Funct7Save;
            sreg_batch_start = cur_q;
            sreg_batch_len   = blen[4:0];
        end
    end

    // Save lanes: lanes past the batch end, and x0, send zero.
    always_comb begin
        for (int unsigned k = 0; k < RS_MAX; k++) begin
            rf_raddr[k]    = cur_q + 5'(k);
            sreg_rs_val[k] = 32'd0;
            if ((state_q == StReq) && !restore_q && (6'(k) < blen) && (rf_raddr[k] != 5'd0)) begin
                sreg_rs_val[k] = rf_rdata[k];
            end
        end
    end

    // Restore lanes: write only in an error-free ack cycle, never to x0.
    always_comb begin
        for (int unsigned k = 0; k < RD_MAX; k++) begin
            rf_waddr[k] = cur_q + 5'(k);
            rf_wdata[k] = sreg_rd_val[k];
            rf_we[k]    = batch_ok && restore_q && (6'(k) < blen) && (rf_waddr[k] != 5'd0);
        end
    end

endmodule

// File: tb/tb_snapreg_seq.sv
// Directed bench for snapreg_seq: table of whole commands plus hand-written
// sequences for stalls, responder errors and mid-command reset.
module tb_snapreg_seq;

    localparam int unsigned RS_MAX = 4;
    localparam int unsigned RD_MAX = 4;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic                     cmd_restore;
    logic [4:0]               cmd_start;
    logic [5:0]               cmd_len;
    logic                     done_o;
    logic                     err_o;
    logic                     sreg_req;
    logic [6:0]               sreg_funct7;
    logic [4:0]               sreg_batch_start;
    logic [4:0]               sreg_batch_len;
    logic [RS_MAX-1:0][31:0]  sreg_rs_val;
    logic                     sreg_ack;
    logic                     sreg_error;
    logic [RD_MAX-1:0][31:0]  sreg_rd_val;
    logic [RS_MAX-1:0][4:0]   rf_raddr;
    logic [RS_MAX-1:0][31:0]  rf_rdata;
    logic [RD_MAX-1:0]        rf_we;
    logic [RD_MAX-1:0][4:0]   rf_waddr;
    logic [RD_MAX-1:0][31:0]  rf_wdata;

    logic ack_en;
    logic err_drive;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    snapreg_seq #(.RS_MAX(RS_MAX), .RD_MAX(RD_MAX)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_restore      (cmd_restore),
        .cmd_start        (cmd_start),
        .cmd_len          (cmd_len),
        .done_o           (done_o),
        .err_o            (err_o),
        .sreg_req         (sreg_req),
        .sreg_funct7      (sreg_funct7),
        .sreg_batch_start (sreg_batch_start),
        .sreg_batch_len   (sreg_batch_len),
        .sreg_rs_val      (sreg_rs_val),
        .sreg_ack         (sreg_ack),
        .sreg_error       (sreg_error),
        .sreg_rd_val      (sreg_rd_val),
        .rf_raddr         (rf_raddr),
        .rf_rdata         (rf_rdata),
        .rf_we            (rf_we),
        .rf_waddr         (rf_waddr),
        .rf_wdata         (rf_wdata)
    );

    // GPR model: x0 reads 0, xi reads 0x100+i.
    always_comb begin
        for (int k = 0; k < RS_MAX; k++) begin
            rf_rdata[k] = (rf_raddr[k] == 5'd0) ? 32'd0 : 32'h100 + 32'(rf_raddr[k]);
        end
    end

    assign sreg_ack   = sreg_req & ack_en;
    assign sreg_error = err_drive;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Called at posedge+1 with the DUT idle; returns at posedge+1 of the acceptance edge.
    task automatic issue(input logic r, input logic [4:0] s, input logic [5:0] l);
        cmd_valid   = 1'b1;
        cmd_restore = r;
        cmd_start   = s;
        cmd_len     = l;
        @(posedge clk); #1;
        cmd_valid   = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic run_cmd(input logic r, input logic [4:0] s, input logic [5:0] l,
                           output int nb, output int ncyc, output logic e, output int flen);
        logic got_done;
        got_done = 1'b0;
        nb = 0; ncyc = -1; e = 1'b0; flen = 0;
        issue(r, s, l);
        for (int c = 1; c <= 64 && !got_done; c++) begin
            #4;
            if (sreg_req) begin
                if (nb == 0) flen = int'(sreg_batch_len);
                if (sreg_ack) nb++;
            end
            if (done_o) begin
                got_done = 1'b1;
                ncyc     = c;
                e        = err_o;
            end
            next_cycle();
        end
    endtask

    typedef struct {
        logic       restore;
        logic [4:0] start;
        logic [5:0] len;
        int         nb;
        int         cyc;
        logic       err;
        int         flen;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int   nb, ncyc, fl, acks;
        logic e, seen_done;

        vecs[0] = '{1'b0, 5'd5,  6'd6,  2, 3, 1'b0, 4};
        vecs[1] = '{1'b1, 5'd0,  6'd3,  1, 2, 1'b0, 3};
        vecs[2] = '{1'b0, 5'd30, 6'd4,  0, 1, 1'b1, 0};
        vecs[3] = '{1'b0, 5'd0,  6'd32, 8, 9, 1'b0, 4};
        vecs[4] = '{1'b1, 5'd31, 6'd1,  1, 2, 1'b0, 1};
        vecs[5] = '{1'b0, 5'd0,  6'd0,  0, 1, 1'b1, 0};
        vecs[6] = '{1'b0, 5'd28, 6'd4,  1, 2, 1'b0, 4};
        vecs[7] = '{1'b1, 5'd28, 6'd5,  0, 1, 1'b1, 0};
        vecs[8] = '{1'b0, 5'd0,  6'd33, 0, 1, 1'b1, 0};
        vecs[9] = '{1'b1, 5'd1,  6'd9,  3, 4, 1'b0, 4};

        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_restore = 1'b0;
        cmd_start   = 5'd0;
        cmd_len     = 6'd0;
        ack_en      = 1'b1;
        err_drive   = 1'b0;
        sreg_rd_val = {32'hDD, 32'hCC, 32'hBB, 32'hAA};

        #3;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_req", 32'(sreg_req), 32'd0);
        chk("rst_we", 32'(rf_we), 32'd0);
        #9 rst_n = 1'b1;
        next_cycle();

        // Save start=5 len=6
        issue(1'b0, 5'd5, 6'd6);
        #4;
        chk("sv_c1_req", 32'(sreg_req), 32'd1);
        chk("sv_c1_f7", 32'(sreg_funct7), 32'h00);
        chk("sv_c1_start", 32'(sreg_batch_start), 32'd5);
        chk("sv_c1_len", 32'(sreg_batch_len), 32'd4);
        chk("sv_c1_rs0", sreg_rs_val[0], 32'h105);
        chk("sv_c1_rs1", sreg_rs_val[1], 32'h106);
        chk("sv_c1_rs2", sreg_rs_val[2], 32'h107);
        chk("sv_c1_rs3", sreg_rs_val[3], 32'h108);
        next_cycle(); #4;
        chk("sv_c2_start", 32'(sreg_batch_start), 32'd9);
        chk("sv_c2_len", 32'(sreg_batch_len), 32'd2);
        chk("sv_c2_rs0", sreg_rs_val[0], 32'h109);
        chk("sv_c2_rs1", sreg_rs_val[1], 32'h10A);
        chk("sv_c2_rs2", sreg_rs_val[2], 32'h0);
        chk("sv_c2_rs3", sreg_rs_val[3], 32'h0);
        next_cycle(); #4;
        chk("sv_c3_done", 32'(done_o), 32'd1);
        chk("sv_c3_err", 32'(err_o), 32'd0);
        chk("sv_c3_req", 32'(sreg_req), 32'd0);
        next_cycle();

        // Save len=8 with a 3-cycle stall on the second batch
        acks = 0;
        issue(1'b0, 5'd0, 6'd8);
        #4;
        chk("st_c1_start", 32'(sreg_batch_start), 32'd0);
        if (sreg_req && sreg_ack) acks++;
        next_cycle();
        ack_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #4;
            chk("st_hold_req", 32'(sreg_req), 32'd1);
            chk("st_hold_start", 32'(sreg_batch_start), 32'd4);
            chk("st_hold_rs0", sreg_rs_val[0], 32'h104);
            chk("st_hold_rs3", sreg_rs_val[3], 32'h107);
            chk("st_hold_done", 32'(done_o), 32'd0);
            if (sreg_req && sreg_ack) acks++;
            next_cycle();
        end
        ack_en = 1'b1;
        #4;
        chk("st_ack_start", 32'(sreg_batch_start), 32'd4);
        chk("st_ack_rs0", sreg_rs_val[0], 32'h104);
        if (sreg_req && sreg_ack) acks++;
        next_cycle(); #4;
        chk("st_done", 32'(done_o), 32'd1);
        chk("st_err", 32'(err_o), 32'd0);
        chk("st_acks", 32'(acks), 32'd2);
        next_cycle();

        // Restore start=0 len=3: x0 lane must not write
        issue(1'b1, 5'd0, 6'd3);
        #4;
        chk("rs_f7", 32'(sreg_funct7), 32'h40);
        chk("rs_len", 32'(sreg_batch_len), 32'd3);
        chk("rs_we", 32'(rf_we), 32'b0110);
        chk("rs_wa1", 32'(rf_waddr[1]), 32'd1);
        chk("rs_wa2", 32'(rf_waddr[2]), 32'd2);
        chk("rs_wd1", rf_wdata[1], 32'hBB);
        chk("rs_wd2", rf_wdata[2], 32'hCC);
        next_cycle(); #4;
        chk("rs_done", 32'(done_o), 32'd1);
        chk("rs_err", 32'(err_o), 32'd0);
        chk("rs_we_after", 32'(rf_we), 32'd0);
        next_cycle();

        // Responder error on the first batch of restore start=8 len=8
        err_drive = 1'b1;
        issue(1'b1, 5'd8, 6'd8);
        #4;
        chk("er_req", 32'(sreg_req), 32'd1);
        chk("er_start", 32'(sreg_batch_start), 32'd8);
        chk("er_we", 32'(rf_we), 32'd0);
        next_cycle(); #4;
        chk("er_done", 32'(done_o), 32'd1);
        chk("er_err", 32'(err_o), 32'd1);
        chk("er_no_req", 32'(sreg_req), 32'd0);
        next_cycle();
        err_drive = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_cmd(vecs[i].restore, vecs[i].start, vecs[i].len, nb, ncyc, e, fl);
            chk($sformatf("vec%0d_batches", i), 32'(nb), 32'(vecs[i].nb));
            chk($sformatf("vec%0d_cycles", i), 32'(ncyc), 32'(vecs[i].cyc));
            chk($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].err));
            chk($sformatf("vec%0d_first_len", i), 32'(fl), 32'(vecs[i].flen));
        end

        // Reset in the middle of a save len=32
        issue(1'b0, 5'd0, 6'd32);
        next_cycle(); #4;
        chk("rr_pre_start", 32'(sreg_batch_start), 32'd4);
        rst_n = 1'b0;
        #1;
        chk("rr_req", 32'(sreg_req), 32'd0);
        chk("rr_ready", 32'(cmd_ready), 32'd1);
        seen_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            next_cycle(); #4;
            if (done_o) seen_done = 1'b1;
        end
        rst_n = 1'b1;
        next_cycle(); #4;
        if (done_o) seen_done = 1'b1;
        chk("rr_no_done", 32'(seen_done), 32'd0);
        next_cycle();
        run_cmd(1'b0, 5'd5, 6'd6, nb, ncyc, e, fl);
        chk("rr_after_batches", 32'(nb), 32'd2);
        chk("rr_after_cycles", 32'(ncyc), 32'd3);
        chk("rr_after_err", 32'(e), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
